// File: rtl/coreport_pkg.sv
// Shared constants and helpers for the coreport GPIO input path.
package coreport_pkg;

  localparam int COREPORT_WIDTH       = 8;
  localparam int COREPORT_SYNC_STAGES = 2;
  localparam int COREPORT_CNT_W       = 4;
  localparam int COREPORT_PRESCALE_W  = 16;

  // A threshold of zero would accept a change without any stability time,
  // so it is treated the same as one tick.
  function automatic int unsigned eff_threshold(input int unsigned thr);
    return (thr == 0) ? 1 : thr;
  endfunction

endpackage

// File: rtl/coreport_filter_bit.sv
// One pin of the input filter: synchroniser chain, stability counter,
// filtered level and registered rise/fall strobes.
module coreport_filter_bit
  import coreport_pkg::*;
#(
  parameter int   SYNC_STAGES = COREPORT_SYNC_STAGES,
  parameter int   CNT_W       = COREPORT_CNT_W,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             pin_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic             bypass_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  logic                   sync_out;
  logic [CNT_W:0]         thr_eff;
  logic [CNT_W:0]         cnt_inc;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign thr_eff  = (CNT_W+1)'(eff_threshold(32'(threshold_i)));
  assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Next-state logic: shift the synchroniser, then decide whether the
  // synchronised value has been stable long enough to become the new level.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (bypass_i) begin
      level_d = sync_out;
      cnt_d   = '0;
    end else if (sync_out == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_inc >= thr_eff) begin
        level_d = sync_out;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // State registers; reset leaves sync chain and level equal so that no
  // strobe can appear on reset release.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/coreport_input_filter.sv
// Input conditioning in front of coreport: shared sample prescaler plus one
// synchronise/debounce/edge-detect slice per pin.
module coreport_input_filter
  import coreport_pkg::*;
#(
  parameter int               WIDTH       = COREPORT_WIDTH,
  parameter int               SYNC_STAGES = COREPORT_SYNC_STAGES,
  parameter int               PRESCALE_W  = COREPORT_PRESCALE_W,
  parameter int               CNT_W       = COREPORT_CNT_W,
  parameter logic [WIDTH-1:0] INIT_LEVEL  = '0
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [WIDTH-1:0]      pin_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0]      threshold_i,
  input  logic [WIDTH-1:0]      bypass_i,
  output logic [WIDTH-1:0]      level_o,
  output logic [WIDTH-1:0]      rise_o,
  output logic [WIDTH-1:0]      fall_o,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  tick_q, tick_d;
  logic                  tick;

  // Prescaler: a >= compare so lowering prescale_i below the running count
  // produces a tick straight away instead of waiting for a wrap.
  always_comb begin
    tick   = (pcnt_q >= prescale_i);
    pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    tick_d = tick;
  end

  // Prescaler count and the observable copy of the tick.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    coreport_filter_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .INIT_LEVEL  (INIT_LEVEL[i])
    ) u_bit (
      .wb_clk      (wb_clk),
      .wb_rst      (wb_rst),
      .pin_i       (pin_i[i]),
      .tick_i      (tick),
      .threshold_i (threshold_i),
      .bypass_i    (bypass_i[i]),
      .level_o     (level_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i])
    );
  end

endmodule

// File: tb/tb_coreport_input_filter.sv
// Testbench for coreport_input_filter: directed stimulus with a scoreboard of
// expected rise/fall events checked by an independent monitor.
module tb_coreport_input_filter;

  localparam int        WIDTH       = 8;
  localparam int        SYNC_STAGES = 2;
  localparam int        PRESCALE_W  = 16;
  localparam int        CNT_W       = 4;
  localparam logic [7:0] INIT       = 8'hA5;

  logic                  wb_clk = 1'b0;
  logic                  wb_rst = 1'b1;
  logic [WIDTH-1:0]      pin_i = '0;
  logic [PRESCALE_W-1:0] prescale_i = '0;
  logic [CNT_W-1:0]      threshold_i = 4'd4;
  logic [WIDTH-1:0]      bypass_i = '0;
  logic [WIDTH-1:0]      level_o;
  logic [WIDTH-1:0]      rise_o;
  logic [WIDTH-1:0]      fall_o;
  logic                  tick_o;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] level;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;

  coreport_input_filter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .PRESCALE_W  (PRESCALE_W),
    .CNT_W       (CNT_W),
    .INIT_LEVEL  (INIT)
  ) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .pin_i       (pin_i),
    .prescale_i  (prescale_i),
    .threshold_i (threshold_i),
    .bypass_i    (bypass_i),
    .level_o     (level_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .tick_o      (tick_o)
  );

  // 10 ns clock
  always #5 wb_clk = ~wb_clk;

  // Cycle counter: value seen at a negedge is the number of posedges so far
  always @(posedge wb_clk) cyc <= cyc + 1;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pins);
    pin_i = pins;
  endtask

  task automatic expectEvent(input int c, input logic [7:0] r, input logic [7:0] f, input logic [7:0] l);
    exp_t e;
    e.cyc   = c;
    e.rise  = r;
    e.fall  = f;
    e.level = l;
    sbQ.push_back(e);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge wb_clk);
  endtask

  task automatic syncToTick();
    @(negedge wb_clk);
    for (int k = 0; k < 25 && tick_o !== 1'b1; k++) @(negedge wb_clk);
    checkOutput("tick_found", 32'(tick_o), 32'd1);
  endtask

  // Monitor: every strobe the DUT shows must match the oldest queued event
  always @(negedge wb_clk) begin
    if (!wb_rst && ((rise_o | fall_o) != '0)) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe: got rise=%0h fall=%0h level=%0h at cycle %0d, expected no strobe",
                 rise_o, fall_o, level_o, cyc);
      end else begin
        monE = sbQ.pop_front();
        if (cyc != monE.cyc || rise_o !== monE.rise || fall_o !== monE.fall || level_o !== monE.level) begin
          errors++;
          $display("[TB] FAIL event: got cyc=%0d rise=%0h fall=%0h level=%0h, expected cyc=%0d rise=%0h fall=%0h level=%0h",
                   cyc, rise_o, fall_o, level_o, monE.cyc, monE.rise, monE.fall, monE.level);
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    int c;
    int c0;
    int e;

    // Reset with pins differing from INIT: no strobe at release, then debounce to 00
    repeat (3) @(negedge wb_clk);
    checkOutput("reset_level", 32'(level_o), 32'hA5);
    checkOutput("reset_rise", 32'(rise_o), 32'h0);
    checkOutput("reset_fall", 32'(fall_o), 32'h0);
    checkOutput("reset_tick", 32'(tick_o), 32'h0);
    wb_rst = 1'b0;
    c0 = cyc;
    expectEvent(c0 + 6, 8'h00, 8'hA5, 8'h00);
    waitUntil(c0 + 1);
    checkOutput("release_rise", 32'(rise_o), 32'h0);
    checkOutput("release_fall", 32'(fall_o), 32'h0);
    waitUntil(c0 + 5);
    checkOutput("release_hold_level", 32'(level_o), 32'hA5);
    waitUntil(c0 + 8);
    checkOutput("release_final_level", 32'(level_o), 32'h00);

    // Bypass: level follows the synchroniser one cycle later
    bypass_i = 8'hFF;
    repeat (2) @(negedge wb_clk);
    c = cyc;
    applyStimulus(8'h01);
    expectEvent(c + 3, 8'h01, 8'h00, 8'h01);
    waitUntil(c + 2);
    checkOutput("bypass_before", 32'(level_o), 32'h00);
    waitUntil(c + 6);
    bypass_i = 8'h00;
    repeat (3) @(negedge wb_clk);
    checkOutput("bypass_off_level", 32'(level_o), 32'h01);

    // Debounce, prescale 0, threshold 4: a 3-cycle glitch is rejected
    c = cyc;
    applyStimulus(8'h03);
    waitUntil(c + 3);
    applyStimulus(8'h01);
    waitUntil(c + 10);
    checkOutput("glitch_level", 32'(level_o), 32'h01);

    // A held change is accepted 6 cycles later
    c = cyc;
    applyStimulus(8'h03);
    expectEvent(c + 6, 8'h02, 8'h00, 8'h03);
    waitUntil(c + 5);
    checkOutput("debounce_before", 32'(level_o), 32'h01);
    waitUntil(c + 8);
    checkOutput("debounce_after", 32'(level_o), 32'h03);

    // Prescaler 9, threshold 3: accepted on the third tick after sync
    prescale_i  = 16'd9;
    threshold_i = 4'd3;
    syncToTick();
    e = cyc;
    applyStimulus(8'h01);
    expectEvent(e + 30, 8'h00, 8'h02, 8'h01);
    waitUntil(e + 9);
    checkOutput("tick_gap", 32'(tick_o), 32'h0);
    waitUntil(e + 10);
    checkOutput("tick_10", 32'(tick_o), 32'h1);
    waitUntil(e + 11);
    checkOutput("tick_width", 32'(tick_o), 32'h0);
    waitUntil(e + 20);
    checkOutput("tick_20", 32'(tick_o), 32'h1);
    waitUntil(e + 29);
    checkOutput("prescale_before", 32'(level_o), 32'h03);
    waitUntil(e + 32);
    checkOutput("prescale_after", 32'(level_o), 32'h01);

    // Threshold 1 and threshold 0: both accept on the first tick after sync
    threshold_i = 4'd1;
    syncToTick();
    e = cyc;
    applyStimulus(8'h09);
    expectEvent(e + 10, 8'h08, 8'h00, 8'h09);
    waitUntil(e + 9);
    checkOutput("thr1_before", 32'(level_o), 32'h01);
    waitUntil(e + 12);
    checkOutput("thr1_after", 32'(level_o), 32'h09);

    threshold_i = 4'd0;
    syncToTick();
    e = cyc;
    applyStimulus(8'h0D);
    expectEvent(e + 10, 8'h04, 8'h00, 8'h0D);
    waitUntil(e + 9);
    checkOutput("thr0_before", 32'(level_o), 32'h09);
    waitUntil(e + 12);
    checkOutput("thr0_after", 32'(level_o), 32'h0D);

    // Asynchronous reset while a count of 2 of 4 is in progress
    prescale_i  = 16'd0;
    threshold_i = 4'd4;
    repeat (3) @(negedge wb_clk);
    c = cyc;
    applyStimulus(8'h1D);
    waitUntil(c + 4);
    checkOutput("midcount_level", 32'(level_o), 32'h0D);
    wb_rst = 1'b1;
    #1;
    checkOutput("async_level", 32'(level_o), 32'hA5);
    checkOutput("async_rise", 32'(rise_o), 32'h0);
    checkOutput("async_fall", 32'(fall_o), 32'h0);
    checkOutput("async_tick", 32'(tick_o), 32'h0);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    c0 = cyc;
    expectEvent(c0 + 6, 8'h18, 8'hA0, 8'h1D);
    waitUntil(c0 + 5);
    checkOutput("rerelease_hold", 32'(level_o), 32'hA5);
    waitUntil(c0 + 8);
    checkOutput("rerelease_final", 32'(level_o), 32'h1D);

    // All queued events must have been seen
    repeat (3) @(negedge wb_clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_events: got %0d left in queue, expected 0", sbQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
